// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/status bundle between the pipeline control logic (master)
// and the program counter sequencer (slave).
interface pc_sequencer_if #(
  parameter int AW = 16
);
  // No valid/ready handshake: every control input is sampled on each rising
  // clk edge and acts only when en=1 and stall=0; outputs are valid every cycle.
  logic          en;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          jump;
  logic          call;
  logic [AW-1:0] jump_target;
  logic          ret;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_err;

  modport master (
    output en, stall, branch_taken, branch_target, jump, call, jump_target, ret,
    input  pc, pc_plus, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  en, stall, branch_taken, branch_target, jump, call, jump_target, ret,
    output pc, pc_plus, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter with stall hold, branch/jump redirect and a circular
// return-address stack for call/return.
module pc_sequencer #(
  parameter int            AW        = 16,
  parameter int            INC       = 1,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int            PW      = $clog2(RAS_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [AW-1:0] INC_V   = AW'(INC);
  localparam logic [CW-1:0] DEPTH_V = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  logic          advance;
  logic          push;
  logic [AW-1:0] pc_plus;
  logic [PW-1:0] top_idx;

  assign pc_plus = pc_q + INC_V;
  assign advance = bus.en & ~bus.stall;
  // wp_q is the next free slot; the newest entry sits just below it.
  assign top_idx = wp_q - ONE_P;

  always_comb begin
    pc_d  = pc_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (advance) begin
      if (bus.branch_taken) begin
        pc_d = bus.branch_target;
      end else if (bus.ret && bus.call) begin
        pc_d  = pc_plus;
        err_d = 1'b1;
      end else if (bus.ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[top_idx];
          wp_d  = top_idx;
          cnt_d = cnt_q - ONE_C;
        end else begin
          pc_d  = pc_plus;
          err_d = 1'b1;
        end
      end else if (bus.call) begin
        // When full, slot wp_q holds the oldest entry, so the push overwrites it.
        push = 1'b1;
        pc_d = bus.jump_target;
        wp_d = wp_q + ONE_P;
        if (cnt_q == DEPTH_V) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end else if (bus.jump) begin
        pc_d = bus.jump_target;
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras_q[wp_q] <= pc_plus;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == DEPTH_V);
  assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_pc_sequencer;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.AW(AW)) bus ();

  pc_sequencer #(
    .AW(AW), .INC(1), .RESET_PC(16'h0000), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: return stack as a plain queue, newest at the back.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ras[$];
  logic          m_err;
  logic [AW-1:0] m_next;

  always @(posedge clk) begin
    if (rst) begin
      m_pc  = 16'h0000;
      m_ras.delete();
      m_err = 1'b0;
    end else if (bus.en && !bus.stall) begin
      m_next = m_pc + 16'd1;
      if (bus.branch_taken) begin
        m_pc = bus.branch_target;
      end else if (bus.ret && bus.call) begin
        m_pc  = m_next;
        m_err = 1'b1;
      end else if (bus.ret) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc  = m_next;
          m_err = 1'b1;
        end
      end else if (bus.call) begin
        m_ras.push_back(m_next);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
        m_pc = bus.jump_target;
      end else if (bus.jump) begin
        m_pc = bus.jump_target;
      end else begin
        m_pc = m_next;
      end
    end
  end

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", bus.pc, m_pc);
      check("model_pc_plus", bus.pc_plus, m_pc + 16'd1);
      check("model_empty", {15'd0, bus.ras_empty}, {15'd0, m_ras.size() == 0});
      check("model_full", {15'd0, bus.ras_full}, {15'd0, m_ras.size() == DEPTH});
      check("model_err", {15'd0, bus.ras_err}, {15'd0, m_err});
    end
  end

  task automatic set_idle();
    bus.en            = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.jump_target   = '0;
    bus.ret           = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic do_jump(input logic [AW-1:0] t);
    bus.jump = 1'b1; bus.jump_target = t; tick();
  endtask

  task automatic do_call(input logic [AW-1:0] t);
    bus.call = 1'b1; bus.jump_target = t; tick();
  endtask

  task automatic do_ret();
    bus.ret = 1'b1; tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    set_idle();
    // T1: reset then three advances
    do_reset();
    chk_en = 1'b1;
    check("t1_reset_pc", bus.pc, 16'h0000);
    check("t1_reset_empty", {15'd0, bus.ras_empty}, 16'd1);
    check("t1_reset_full", {15'd0, bus.ras_full}, 16'd0);
    check("t1_reset_err", {15'd0, bus.ras_err}, 16'd0);
    tick(); check("t1_pc1", bus.pc, 16'h0001);
    tick(); check("t1_pc2", bus.pc, 16'h0002);
    tick(); check("t1_pc3", bus.pc, 16'h0003);
    check("t1_empty", {15'd0, bus.ras_empty}, 16'd1);

    // T2: wrap at the top of the address space
    do_jump(16'hFFFF);
    check("t2_pc_ffff", bus.pc, 16'hFFFF);
    check("t2_pc_plus_wrap", bus.pc_plus, 16'h0000);
    tick();
    check("t2_pc_wrap", bus.pc, 16'h0000);
    check("t2_err", {15'd0, bus.ras_err}, 16'd0);

    // T3: simple call / return
    do_jump(16'h0010);
    do_call(16'h0100);
    check("t3_call_pc", bus.pc, 16'h0100);
    check("t3_not_empty", {15'd0, bus.ras_empty}, 16'd0);
    do_ret();
    check("t3_ret_pc", bus.pc, 16'h0011);
    check("t3_empty", {15'd0, bus.ras_empty}, 16'd1);

    // T4: overflow by one, then drain in LIFO order and underflow
    do_call(16'h1000);
    do_call(16'h2000);
    do_call(16'h3000);
    do_call(16'h4000);
    check("t4_full4", {15'd0, bus.ras_full}, 16'd1);
    check("t4_err_before", {15'd0, bus.ras_err}, 16'd0);
    do_call(16'h5000);
    check("t4_pc5", bus.pc, 16'h5000);
    check("t4_full5", {15'd0, bus.ras_full}, 16'd1);
    check("t4_err_ovf", {15'd0, bus.ras_err}, 16'd1);
    do_ret(); check("t4_ret1", bus.pc, 16'h4001);
    do_ret(); check("t4_ret2", bus.pc, 16'h3001);
    do_ret(); check("t4_ret3", bus.pc, 16'h2001);
    do_ret(); check("t4_ret4", bus.pc, 16'h1001);
    check("t4_empty_after4", {15'd0, bus.ras_empty}, 16'd1);
    do_ret(); check("t4_ret5_underflow", bus.pc, 16'h1002);
    check("t4_empty", {15'd0, bus.ras_empty}, 16'd1);

    // T5: branch beats call/ret; stall and en=0 hold everything
    do_call(16'h0300);
    check("t5_call_pc", bus.pc, 16'h0300);
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0200;
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump_target = 16'h0700;
    tick();
    check("t5_branch_pc", bus.pc, 16'h0200);
    check("t5_branch_ras", {15'd0, bus.ras_empty}, 16'd0);
    bus.stall = 1'b1; bus.call = 1'b1; bus.jump_target = 16'h0500;
    tick();
    check("t5_stall_pc", bus.pc, 16'h0200);
    bus.en = 1'b0; bus.jump = 1'b1; bus.jump_target = 16'h0600;
    tick();
    check("t5_en0_pc", bus.pc, 16'h0200);
    do_ret();
    check("t5_ret_pc", bus.pc, 16'h1003);
    check("t5_ret_empty", {15'd0, bus.ras_empty}, 16'd1);

    // T6: reset in the middle of a call sequence, then underflow
    do_call(16'h0A00);
    do_call(16'h0B00);
    bus.call = 1'b1; bus.jump_target = 16'h0C00;
    do_reset();
    check("t6_rst_pc", bus.pc, 16'h0000);
    check("t6_rst_empty", {15'd0, bus.ras_empty}, 16'd1);
    check("t6_rst_err", {15'd0, bus.ras_err}, 16'd0);
    do_ret();
    check("t6_ret_pc", bus.pc, 16'h0001);
    check("t6_ret_err", {15'd0, bus.ras_err}, 16'd1);

    // call+ret conflict after a fresh reset
    do_reset();
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump_target = 16'h0900;
    tick();
    check("conflict_pc", bus.pc, 16'h0001);
    check("conflict_err", {15'd0, bus.ras_err}, 16'd1);
    check("conflict_empty", {15'd0, bus.ras_empty}, 16'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
